// File: rtl/order_content_arbiter.sv
// order_content_arbiter
//
// Sequencer and arbiter for the single-port order-content RAM. After reset,
// and whenever clear_req is seen while running, it writes zero to every RAM
// entry. Once the sweep is done it shares the RAM port between a write
// requester and a read requester. When both are valid in the same cycle, the
// one that did not win the last completed handshake is granted. Read data
// comes straight from the RAM's registered output, one cycle after the grant.
//
// State table:
//   state    | meaning
//   ST_START | just out of reset, no RAM access, moves to ST_INIT next clock
//   ST_INIT  | zero sweep, one address per cycle (sweep_cnt)
//   ST_RUN   | init_done=1, wr/rd requests arbitrated onto the RAM port
//
// Ports:
//   axis_aclk, axis_resetn     clock, async active-low reset
//   clear_req                  pulse: restart the zero sweep (honoured in RUN only)
//   init_done                  RAM cleared, requests are being served
//   wr_valid/ready/addr/data   write request handshake
//   rd_valid/ready/addr        read request handshake
//   rd_rsp_valid/rd_rsp_data   read response, one cycle after the grant
//   ram_addr/din/we            combinational drive of the RAM port
//   ram_dout                   registered RAM read data

module order_content_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 200
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  clear_req,
  output logic                  init_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {ST_START, ST_INIT, ST_RUN} state_t;
  typedef enum logic {GNT_WR, GNT_RD} grant_t;

  localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  grant_t                  last_grant_q, last_grant_d;
  logic                    init_done_q, init_done_d;
  logic                    rd_rsp_valid_q, rd_rsp_valid_d;

  logic                    run;
  logic                    wr_grant;
  logic                    rd_grant;

  // Ready is not gated by the requester's own valid: an idle port sees
  // ready=1, and contention resolves through the other side's valid.
  always_comb begin
    run      = (state_q == ST_RUN);
    wr_ready = run && !clear_req && (!rd_valid || (last_grant_q == GNT_RD));
    rd_ready = run && !clear_req && (!wr_valid || (last_grant_q == GNT_WR));
    wr_grant = wr_valid && wr_ready;
    rd_grant = rd_valid && rd_ready;
  end

  // RAM port drive. With no access the address keeps its last value so the
  // RAM address pins do not toggle needlessly.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_hold_q;
    ram_din  = '0;
    if (state_q == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = sweep_cnt_q;
    end else if (wr_grant) begin
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end else if (rd_grant) begin
      ram_addr = rd_addr;
    end
  end

  always_comb begin
    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    init_done_d    = init_done_q;
    last_grant_d   = last_grant_q;
    addr_hold_d    = ram_addr;
    rd_rsp_valid_d = rd_grant;

    if (wr_grant) begin
      last_grant_d = GNT_WR;
    end else if (rd_grant) begin
      last_grant_d = GNT_RD;
    end

    case (state_q)
      ST_START: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        if (sweep_cnt_q == SWEEP_LAST) begin
          state_d     = ST_RUN;
          sweep_cnt_d = '0;
          init_done_d = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_START;
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q        <= ST_START;
      sweep_cnt_q    <= '0;
      addr_hold_q    <= '0;
      last_grant_q   <= GNT_RD;
      init_done_q    <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sweep_cnt_q    <= sweep_cnt_d;
      addr_hold_q    <= addr_hold_d;
      last_grant_q   <= last_grant_d;
      init_done_q    <= init_done_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
    end
  end

  assign init_done    = init_done_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data  = ram_dout;

endmodule
